pipe_pack: RTL and testbench

- Width up-converter (packer) for the valid/hold streaming fabric.
- Accumulates RATIO narrow beats of DW bits into one wide word of DW*RATIO bits.
- A beat carrying di_last closes a partial word early.
- Sits directly upstream of a wide pipeline stage and presents a registered valid/hold output that plugs into that stage's input.

---
 rtl/pipe_pack.sv | 84 ++++++++
 tb/tb_pipe_pack.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_pack.sv
// Width up-converter: packs RATIO narrow beats of DW bits into one registered
// wide word on a valid/hold stream; a beat with di_last closes a word early.
module pipe_pack #(
    parameter int DW    = 8,
    parameter int RATIO = 4,
    parameter int CW    = $clog2(RATIO + 1)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                di_valid,
    input  logic [DW-1:0]       di,
    input  logic                di_last,
    output logic                di_hold,
    output logic                q_valid,
    output logic [DW*RATIO-1:0] q,
    output logic [CW-1:0]       q_count,
    output logic                q_last,
    input  logic                q_hold
);

    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]          cnt;
    logic [RATIO-1:0][DW-1:0]  acc;
    logic [RATIO-1:0][DW-1:0]  word;
    logic                      accept;
    logic                      complete;

    // Backpressure comes only from the output register, never from the input side.
    assign di_hold  = q_valid & q_hold;
    assign accept   = di_valid & ~di_hold;
    assign complete = accept & ((cnt == LAST_LANE) | di_last);

    // Word presented on completion: stored lanes below cnt, the live beat at
    // cnt, zeros above it.
    always_comb begin
        // NOTE: every lane is assigned on every path, so no latch is inferred.
        word = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (CNT_W'(k) < cnt) begin
                word[k] = acc[k];
            end else if (CNT_W'(k) == cnt) begin
                word[k] = di;
            end
        end
    end

    // Lane counter and accumulator.
    always_ff @(posedge clk) begin
        // NOTE: the accumulator is reset as well, so a discarded partial word
        // can never leak into the next one.
        if (!resetn) begin
            cnt <= '0;
            acc <= '0;
        end else if (complete) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            // NOTE: non-blocking updates keep every register sampling
            // pre-edge values.
            acc[cnt] <= di;
            cnt      <= cnt + 1'b1;
        end
    end

    // Output register: loads whenever it is empty or being consumed.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_valid <= 1'b0;
            q       <= '0;
            q_count <= '0;
            q_last  <= 1'b0;
        end else if (!q_valid || !q_hold) begin
            q_valid <= complete;
            if (complete) begin
                q       <= word;
                q_count <= CW'(cnt) + CW'(1);
                q_last  <= di_last;
            end
        end
    end

endmodule

// File: tb/tb_pipe_pack.sv
// Directed bench for pipe_pack: a per-cycle vector table for RATIO=4 plus
// hand-written reset and RATIO=1 sequences.
module tb_pipe_pack;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        di_valid, di_last, di_hold, q_valid, q_last, q_hold;
    logic [7:0]  di;
    logic [31:0] q;
    logic [2:0]  q_count;

    logic        di_valid1, di_last1, di_hold1, q_valid1, q_last1, q_hold1;
    logic [7:0]  di1, q1;
    logic [0:0]  q_count1;

    pipe_pack #(.DW(DW), .RATIO(4)) u_dut (
        .clk(clk), .resetn(resetn),
        .di_valid(di_valid), .di(di), .di_last(di_last), .di_hold(di_hold),
        .q_valid(q_valid), .q(q), .q_count(q_count), .q_last(q_last),
        .q_hold(q_hold)
    );

    pipe_pack #(.DW(DW), .RATIO(1)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .di_valid(di_valid1), .di(di1), .di_last(di_last1), .di_hold(di_hold1),
        .q_valid(q_valid1), .q(q1), .q_count(q_count1), .q_last(q_last1),
        .q_hold(q_hold1)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        last;
        logic        qh;
        logic        exp_dh;
        logic        exp_qv;
        logic [31:0] exp_q;
        logic [2:0]  exp_cnt;
        logic        exp_last;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic v, input logic [7:0] d, input logic last, input logic qh,
                           input logic dh, input logic qv, input logic [31:0] eq,
                           input logic [2:0] ec, input logic el);
        vec_t t;
        t.v = v; t.d = d; t.last = last; t.qh = qh;
        t.exp_dh = dh; t.exp_qv = qv; t.exp_q = eq; t.exp_cnt = ec; t.exp_last = el;
        vecs.push_back(t);
    endtask

    // Drive a beat before the edge, then sample one time unit after it.
    task automatic beat(input logic v, input logic [7:0] d, input logic last, input logic qh);
        @(negedge clk);
        di_valid = v; di = d; di_last = last; q_hold = qh;
        @(posedge clk);
        #1;
    endtask

    task automatic beat1(input logic v, input logic [7:0] d, input logic last, input logic qh);
        @(negedge clk);
        di_valid1 = v; di1 = d; di_last1 = last; q_hold1 = qh;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic qv, input logic [31:0] eq,
                             input logic [2:0] ec, input logic el);
        check({tag, ".q_valid"}, 64'(q_valid), 64'(qv));
        check({tag, ".q"},       64'(q),       64'(eq));
        check({tag, ".q_count"}, 64'(q_count), 64'(ec));
        check({tag, ".q_last"},  64'(q_last),  64'(el));
    endtask

    initial begin
        resetn = 1'b0;
        di_valid = 0; di = '0; di_last = 0; q_hold = 0;
        di_valid1 = 0; di1 = '0; di_last1 = 0; q_hold1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 32'h0, 3'd0, 1'b0);
        check("reset.di_hold", 64'(di_hold), 64'd0);
        check("reset1.q_valid", 64'(q_valid1), 64'd0);
        check("reset1.q_count", 64'(q_count1), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        //      v  d      last qh   dh qv q              cnt last
        // Continuous stream of eight beats, two full words.
        add_vec(1, 8'h01, 0, 0,   0, 0, 32'h00000000, 0, 0);
        add_vec(1, 8'h02, 0, 0,   0, 0, 32'h00000000, 0, 0);
        add_vec(1, 8'h03, 0, 0,   0, 0, 32'h00000000, 0, 0);
        add_vec(1, 8'h04, 0, 0,   0, 1, 32'h04030201, 4, 0);
        add_vec(1, 8'h05, 0, 0,   0, 0, 32'h04030201, 4, 0);
        add_vec(1, 8'h06, 0, 0,   0, 0, 32'h04030201, 4, 0);
        add_vec(1, 8'h07, 0, 0,   0, 0, 32'h04030201, 4, 0);
        add_vec(1, 8'h08, 0, 0,   0, 1, 32'h08070605, 4, 0);
        // Early close after two beats, then the next beat starts at lane 0.
        add_vec(1, 8'hAA, 0, 0,   0, 0, 32'h08070605, 4, 0);
        add_vec(1, 8'hBB, 1, 0,   0, 1, 32'h0000BBAA, 2, 1);
        add_vec(1, 8'hCC, 0, 0,   0, 0, 32'h0000BBAA, 2, 1);
        add_vec(1, 8'hDD, 0, 0,   0, 0, 32'h0000BBAA, 2, 1);
        add_vec(1, 8'hEE, 0, 0,   0, 0, 32'h0000BBAA, 2, 1);
        add_vec(1, 8'hFF, 0, 0,   0, 1, 32'hFFEEDDCC, 4, 0);
        // Single-beat word, back to back with the previous one.
        add_vec(1, 8'h5A, 1, 0,   0, 1, 32'h0000005A, 1, 1);
        add_vec(0, 8'h00, 0, 0,   0, 0, 32'h0000005A, 1, 1);
        // Fill a word, then stall it for five cycles with noise on the input.
        add_vec(1, 8'h31, 0, 0,   0, 0, 32'h0000005A, 1, 1);
        add_vec(1, 8'h32, 0, 0,   0, 0, 32'h0000005A, 1, 1);
        add_vec(1, 8'h33, 0, 0,   0, 0, 32'h0000005A, 1, 1);
        add_vec(1, 8'h34, 0, 0,   0, 1, 32'h34333231, 4, 0);
        add_vec(1, 8'hEE, 1, 1,   1, 1, 32'h34333231, 4, 0);
        add_vec(0, 8'hEE, 1, 1,   1, 1, 32'h34333231, 4, 0);
        add_vec(1, 8'hEE, 0, 1,   1, 1, 32'h34333231, 4, 0);
        add_vec(1, 8'h41, 1, 1,   1, 1, 32'h34333231, 4, 0);
        add_vec(1, 8'h41, 0, 1,   1, 1, 32'h34333231, 4, 0);
        // Release: the held beat is accepted as lane 0 of the next word.
        add_vec(1, 8'h41, 0, 0,   0, 0, 32'h34333231, 4, 0);
        add_vec(1, 8'h42, 0, 0,   0, 0, 32'h34333231, 4, 0);
        add_vec(1, 8'h43, 0, 0,   0, 0, 32'h34333231, 4, 0);
        add_vec(1, 8'h44, 0, 0,   0, 1, 32'h44434241, 4, 0);
        // Last beat while the previous word is being consumed: no bubble.
        add_vec(1, 8'h51, 1, 0,   0, 1, 32'h00000051, 1, 1);
        add_vec(0, 8'h00, 0, 0,   0, 0, 32'h00000051, 1, 1);
        // q_hold with an empty output does not block the input.
        add_vec(1, 8'h61, 1, 1,   0, 1, 32'h00000061, 1, 1);
        add_vec(1, 8'h62, 0, 1,   1, 1, 32'h00000061, 1, 1);
        add_vec(0, 8'h00, 0, 0,   0, 0, 32'h00000061, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            di_valid = vecs[i].v; di = vecs[i].d; di_last = vecs[i].last; q_hold = vecs[i].qh;
            #1;
            check({tag, ".di_hold"}, 64'(di_hold), 64'(vecs[i].exp_dh));
            @(posedge clk);
            #1;
            check_out(tag, vecs[i].exp_qv, vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_last);
        end

        // Reset in the middle of a word discards the partial beats.
        beat(1, 8'h77, 0, 0);
        beat(1, 8'h78, 0, 0);
        @(negedge clk);
        resetn = 1'b0; di_valid = 0;
        @(posedge clk);
        #1;
        check_out("midreset", 1'b0, 32'h0, 3'd0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        beat(1, 8'h11, 0, 0);
        beat(1, 8'h12, 0, 0);
        beat(1, 8'h13, 0, 0);
        check("postreset.q_valid_early", 64'(q_valid), 64'd0);
        beat(1, 8'h14, 0, 0);
        check_out("postreset", 1'b1, 32'h14131211, 3'd4, 1'b0);
        beat(0, 8'h00, 0, 0);

        // RATIO=1: each beat is a word of one lane.
        beat1(1, 8'h10, 0, 0);
        check("r1a.q_valid", 64'(q_valid1), 64'd1);
        check("r1a.q",       64'(q1),       64'h10);
        check("r1a.q_count", 64'(q_count1), 64'd1);
        check("r1a.q_last",  64'(q_last1),  64'd0);
        beat1(1, 8'h20, 1, 0);
        check("r1b.q_valid", 64'(q_valid1), 64'd1);
        check("r1b.q",       64'(q1),       64'h20);
        check("r1b.q_count", 64'(q_count1), 64'd1);
        check("r1b.q_last",  64'(q_last1),  64'd1);
        @(negedge clk);
        di_valid1 = 1; di1 = 8'h30; di_last1 = 0; q_hold1 = 1;
        #1;
        check("r1stall.di_hold", 64'(di_hold1), 64'd1);
        @(posedge clk);
        #1;
        check("r1stall.q", 64'(q1), 64'h20);
        check("r1stall.q_valid", 64'(q_valid1), 64'd1);
        beat1(1, 8'h30, 0, 0);
        check("r1c.q", 64'(q1), 64'h30);
        check("r1c.q_last", 64'(q_last1), 64'd0);
        beat1(0, 8'h00, 0, 0);
        check("r1d.q_valid", 64'(q_valid1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
